// File: rtl/kctl_pkg.sv
// Shared constants for the NES controller-port responder.
// Build option: KCTL_FOUR_SCORE_EN widens each pad shift register to 24 bits
// so the Four Score multitap (players 3/4 plus a signature byte) is modelled.
package kctl_pkg;

  // Bit positions of each button within a pad byte (active-high).
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

`ifdef KCTL_FOUR_SCORE_EN
  localparam int SR_WIDTH = 24;
`else
  localparam int SR_WIDTH = 8;
`endif

  // Four Score signature bytes, shifted out after players 3/4.
  localparam logic [7:0] SIG_P0 = 8'h08;
  localparam logic [7:0] SIG_P1 = 8'h04;

  // Port 0 address; port 1 sits one above it.
  localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h4016;

endpackage

// File: rtl/kctl_shifter.sv
// Parallel-load, serial-out pad latch modelled on the 4021.
// Shifts right towards bit 0 and fills the top with 1s, so an exhausted
// register keeps returning 1 until the next load.
module kctl_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             ph0,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_value,
  output logic             serial_bit
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Next-state: load has priority over shift; otherwise hold.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_value;
    end else if (shift) begin
      sr_d = {1'b1, sr_q[WIDTH-1:1]};
    end
  end

  // Register update; reset leaves the latch reading as all-released (1s).
  always_ff @(posedge ph0) begin
    if (reset) begin
      sr_q <= '1;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign serial_bit = sr_q[0];

endmodule

// File: rtl/joypad_responder.sv
// CPU-bus responder for the two controller ports ($4016/$4017 by default).
// Decodes completed bus cycles, holds the shared strobe latch, and drives
// serial pad data onto the data bus on reads with zero latency.
// Build option: KCTL_FOUR_SCORE_EN selects 24-bit Four Score shift chains.
module joypad_responder
  import kctl_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter logic [15:0] DECODE_MASK = 16'hFFFF
) (
  input  logic        ph0,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic        rw,
  input  logic        cyc_valid,
  input  logic [7:0]  d_in,
  input  logic [7:0]  open_bus,
  input  logic [7:0]  buttons0,
  input  logic [7:0]  buttons1,
  input  logic [7:0]  buttons2,
  input  logic [7:0]  buttons3,
  output logic [7:0]  d_out,
  output logic        d_oe,
  output logic        strobe_out
);

  localparam logic [15:0] PORT1_ADDR = BASE_ADDR + 16'd1;

  logic                strobe_q;
  logic                strobe_d;
  logic                hit0;
  logic                hit1;
  logic                readHit0;
  logic                readHit1;
  logic                writeHit0;
  logic                srBit0;
  logic                srBit1;
  logic                serialBit;
  logic [SR_WIDTH-1:0] loadValue0;
  logic [SR_WIDTH-1:0] loadValue1;
  logic                unusedBits;

  assign hit0 = ((a ^ BASE_ADDR) & DECODE_MASK) == 16'h0000;
  assign hit1 = ((a ^ PORT1_ADDR) & DECODE_MASK) == 16'h0000;

  // If a loose mask makes both ports decode, port 0 takes the access.
  assign readHit0  = cyc_valid & rw & hit0;
  assign readHit1  = cyc_valid & rw & hit1 & ~hit0;
  assign writeHit0 = cyc_valid & ~rw & hit0;

`ifdef KCTL_FOUR_SCORE_EN
  assign loadValue0 = {SIG_P0, buttons2, buttons0};
  assign loadValue1 = {SIG_P1, buttons3, buttons1};
  assign unusedBits = ^{open_bus[4:0], d_in[7:1]};
`else
  assign loadValue0 = buttons0;
  assign loadValue1 = buttons1;
  assign unusedBits = ^{open_bus[4:0], d_in[7:1], buttons2, buttons3};
`endif

  // Strobe latch next-state: only a write to port 0 changes it.
  always_comb begin
    strobe_d = strobe_q;
    if (writeHit0) begin
      strobe_d = d_in[0];
    end
  end

  // Strobe latch register; reset overrides any same-cycle write.
  always_ff @(posedge ph0) begin
    if (reset) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= strobe_d;
    end
  end

  assign strobe_out = strobe_q;

  // While strobe is high the latches reload every edge; reads only shift
  // when strobe is low, and only the addressed port moves.
  kctl_shifter #(.WIDTH(SR_WIDTH)) u_shifter0 (
    .ph0        (ph0),
    .reset      (reset),
    .load       (strobe_q),
    .shift      (readHit0 & ~strobe_q),
    .load_value (loadValue0),
    .serial_bit (srBit0)
  );

  kctl_shifter #(.WIDTH(SR_WIDTH)) u_shifter1 (
    .ph0        (ph0),
    .reset      (reset),
    .load       (strobe_q),
    .shift      (readHit1 & ~strobe_q),
    .load_value (loadValue1),
    .serial_bit (srBit1)
  );

  // Read-data mux: live button A while strobed, else the latch output;
  // upper bits come from open bus, and nothing is driven outside a read hit.
  always_comb begin
    serialBit = 1'b0;
    d_oe      = 1'b0;
    d_out     = 8'h00;
    if (!reset && (readHit0 || readHit1)) begin
      if (readHit0) begin
        serialBit = strobe_q ? loadValue0[BTN_A] : srBit0;
      end else begin
        serialBit = strobe_q ? loadValue1[BTN_A] : srBit1;
      end
      d_oe  = 1'b1;
      d_out = {open_bus[7:5], 4'b0000, serialBit};
    end
  end

endmodule

// File: tb/tb_joypad_responder.sv
// Directed self-checking bench for joypad_responder.
// Honours KCTL_FOUR_SCORE_EN to add the multitap sequence.
module tb_joypad_responder;

  logic        ph0 = 1'b0;
  logic        reset;
  logic [15:0] a;
  logic        rw;
  logic        cyc_valid;
  logic [7:0]  d_in;
  logic [7:0]  open_bus;
  logic [7:0]  buttons0;
  logic [7:0]  buttons1;
  logic [7:0]  buttons2;
  logic [7:0]  buttons3;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        strobe_out;

  int total = 0;
  int bad   = 0;

  joypad_responder dut (
    .ph0        (ph0),
    .reset      (reset),
    .a          (a),
    .rw         (rw),
    .cyc_valid  (cyc_valid),
    .d_in       (d_in),
    .open_bus   (open_bus),
    .buttons0   (buttons0),
    .buttons1   (buttons1),
    .buttons2   (buttons2),
    .buttons3   (buttons3),
    .d_out      (d_out),
    .d_oe       (d_oe),
    .strobe_out (strobe_out)
  );

  // Free-running system clock, 10 time units per period.
  always #5 ph0 = ~ph0;

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one bus cycle at the falling edge; leaves time to sample
  // the combinational outputs before the next rising edge.
  task automatic applyStimulus(input logic [15:0] addr, input logic rwIn,
                               input logic [7:0] data, input logic valid);
    @(negedge ph0);
    a         = addr;
    rw        = rwIn;
    d_in      = data;
    cyc_valid = valid;
    #2;
  endtask

  task automatic finishCycle();
    @(posedge ph0);
    #1;
    cyc_valid = 1'b0;
    rw        = 1'b1;
  endtask

  task automatic readPort(input logic [15:0] addr, input logic expBit,
                          input string tag);
    applyStimulus(addr, 1'b1, 8'h00, 1'b1);
    checkOutput({tag, "_oe"}, {7'b0, d_oe}, 8'h01);
    checkOutput(tag, d_out, {open_bus[7:5], 4'b0000, expBit});
    finishCycle();
  endtask

  task automatic writePort(input logic [15:0] addr, input logic [7:0] data);
    applyStimulus(addr, 1'b0, data, 1'b1);
    finishCycle();
  endtask

  task automatic latchPads();
    writePort(16'h4016, 8'h01);
    writePort(16'h4016, 8'h00);
  endtask

  initial begin
    logic [9:0]  seqA5;
    logic [25:0] fsExp0;
    logic [25:0] fsExp1;

    reset     = 1'b1;
    a         = 16'h0000;
    rw        = 1'b1;
    cyc_valid = 1'b0;
    d_in      = 8'h00;
    open_bus  = 8'hE0;
    buttons0  = 8'h00;
    buttons1  = 8'h00;
    buttons2  = 8'hFF;
    buttons3  = 8'hFF;

    // Reset state.
    repeat (3) @(posedge ph0);
    #1;
    checkOutput("rst_oe", {7'b0, d_oe}, 8'h00);
    checkOutput("rst_dout", d_out, 8'h00);
    checkOutput("rst_strobe", {7'b0, strobe_out}, 8'h00);
    @(negedge ph0);
    reset = 1'b0;

    // Unstrobed reads after reset return 1 with open-bus upper bits.
    for (int i = 0; i < 3; i++) begin
      readPort(16'h4016, 1'b1, $sformatf("post_rst_r%0d", i));
    end

    // Serialise 8'hA5 then exhaustion.
    buttons0 = 8'hA5;
    latchPads();
    buttons0 = 8'h00;
    seqA5 = 10'b11_1010_0101;
    for (int i = 0; i < 10; i++) begin
      readPort(16'h4016, seqA5[i], $sformatf("a5_r%0d", i + 1));
    end

    // Strobe held high: reads track live bit0, no shifting.
    writePort(16'h4016, 8'h01);
    checkOutput("strobe_hi", {7'b0, strobe_out}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      buttons0 = {7'b0, i[0]};
      readPort(16'h4016, i[0], $sformatf("live_r%0d", i));
    end
    buttons0 = 8'h01;
    writePort(16'h4016, 8'h00);
    buttons0 = 8'h00;
    readPort(16'h4016, 1'b1, "held_r1");
    readPort(16'h4016, 1'b0, "held_r2");

    // Independent ports, interleaved reads.
    open_bus = 8'h5F;
    buttons0 = 8'hFF;
    buttons1 = 8'h00;
    latchPads();
    for (int i = 0; i < 10; i++) begin
      readPort(16'h4016, 1'b1, $sformatf("p0_r%0d", i + 1));
      readPort(16'h4017, (i >= 8), $sformatf("p1_r%0d", i + 1));
    end
    applyStimulus(16'h4017, 1'b0, 8'h01, 1'b1);
    checkOutput("w4017_oe", {7'b0, d_oe}, 8'h00);
    checkOutput("w4017_dout", d_out, 8'h00);
    finishCycle();
    checkOutput("w4017_strobe", {7'b0, strobe_out}, 8'h00);

    // Reset mid-sequence, with a same-cycle strobe write that must lose.
    open_bus = 8'hE0;
    buttons0 = 8'h00;
    latchPads();
    for (int i = 0; i < 3; i++) begin
      readPort(16'h4016, 1'b0, $sformatf("pre_rst_r%0d", i + 1));
    end
    writePort(16'h4016, 8'h01);
    checkOutput("pre_rst_strobe", {7'b0, strobe_out}, 8'h01);
    @(negedge ph0);
    reset     = 1'b1;
    a         = 16'h4016;
    rw        = 1'b0;
    d_in      = 8'h01;
    cyc_valid = 1'b1;
    @(posedge ph0);
    #1;
    reset     = 1'b0;
    cyc_valid = 1'b0;
    rw        = 1'b1;
    checkOutput("mid_rst_strobe", {7'b0, strobe_out}, 8'h00);
    readPort(16'h4016, 1'b1, "mid_rst_r1");

    // Reads without cyc_valid or to a non-hit address do nothing.
    buttons0 = 8'hFE;
    latchPads();
    applyStimulus(16'h4016, 1'b1, 8'h00, 1'b0);
    checkOutput("novalid_oe", {7'b0, d_oe}, 8'h00);
    checkOutput("novalid_dout", d_out, 8'h00);
    finishCycle();
    readPort(16'h4016, 1'b0, "novalid_r1");
    applyStimulus(16'h4018, 1'b1, 8'h00, 1'b1);
    checkOutput("nohit_oe", {7'b0, d_oe}, 8'h00);
    checkOutput("nohit_dout", d_out, 8'h00);
    finishCycle();
    readPort(16'h4016, 1'b1, "novalid_r2");
    readPort(16'h4016, 1'b1, "novalid_r3");

`ifdef KCTL_FOUR_SCORE_EN
    // Four Score: player 3 pad then signature, per port.
    buttons0 = 8'h00;
    buttons1 = 8'h00;
    buttons2 = 8'h01;
    buttons3 = 8'h00;
    latchPads();
    fsExp0 = 26'h3080100;
    fsExp1 = 26'h3040000;
    for (int i = 0; i < 26; i++) begin
      readPort(16'h4016, fsExp0[i], $sformatf("fs_p0_r%0d", i + 1));
      readPort(16'h4017, fsExp1[i], $sformatf("fs_p1_r%0d", i + 1));
    end
`else
    fsExp0 = '0;
    fsExp1 = '0;
`endif

    repeat (2) @(posedge ph0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/joypad_responder.md
Name: joypad_responder

Overview:
- CPU-bus responder for the two NES controller ports at $4016/$4017; the slave side of the bus cycles the k6502 core initiates.
- Decodes the address and R/W of each completed bus cycle, latches the strobe bit on writes, and drives serial button data onto the data bus on reads.
- One shift register per port models the 4021 pad latch. Sits beside the internal-RAM and PPU responders on the CPU data bus.

Parameters:
- BASE_ADDR, 16'h4016, port 0 address; port 1 responds at BASE_ADDR+1.
- DECODE_MASK, 16'hFFFF, address bits compared against BASE_ADDR and BASE_ADDR+1; cleared bits are don't-care (mirroring).

Ports:
- ph0  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- a  in  16  CPU address bus
- rw  in  1  1 = read, 0 = write
- cyc_valid  in  1  one-cycle strobe marking the data-transfer phase of a CPU bus cycle (the ph2 window)
- d_in  in  8  CPU write data
- open_bus  in  8  last value seen on the CPU data bus; supplies undriven bits
- buttons0..buttons3  in  8 each  live pad state, active-high; bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right
- d_out  out  8  read data
- d_oe  out  1  data-bus drive enable
- strobe_out  out  1  current strobe latch (OUT0 pin)

Behaviour:
- Reset: strobe = 0; both shift registers all 1s; strobe_out = 0; d_oe = 0; d_out = 0. Applies mid-sequence; reset wins over a same-cycle bus access.
- Hit definitions:
  - hit0 = ((a ^ BASE_ADDR) & DECODE_MASK) == 0.
  - hit1 uses BASE_ADDR+1 in the same way.
  - A hit counts only when cyc_valid = 1.
- Write, hit0: strobe <= d_in[0] at the end of the cycle. Write, hit1: ignored (owned by the APU frame counter); d_oe stays 0.
- Strobe = 1: every ph0 edge, each port's shift register reloads from its live buttons. Reads return current button A and do not shift.
- Strobe 1 to 0: the last value loaded while strobe = 1 is held. No extra sample on the falling write.
- Read, hitN, strobe = 0: bit = srN[0]. At the end of the same cycle, srN shifts right one place and the MSB fills with 1.
- Read data is combinational in the cycle: d_out = {open_bus[7:5], 4'b0000, bit}; d_oe = cyc_valid & rw & (hit0 | hit1). d_out = 0 whenever d_oe = 0.
- Zero-latency read path: data is valid within the cyc_valid cycle, and the CPU latches it at the end of that cycle. The shift takes effect from the next access.
- Reads without cyc_valid, or to non-hit addresses, change no state.
- Exhaustion: with 8-bit registers, reads 9 and later return 1 indefinitely until the next strobe.
- Ports are independent. Reading port 0 never shifts port 1. Strobe is shared.

Optional Feature:
- Macro: KCTL_FOUR_SCORE_EN.
- Defined: each shift register is 24 bits, loaded as {sig, buttons2/3, buttons0/1}.
  - Port 0 = {8'h08, buttons2, buttons0}; port 1 = {8'h04, buttons3, buttons1}.
  - Reads 1-8 return player 1/2, reads 9-16 return player 3/4, reads 17-24 return the signature (LSB first; a 1 at read 20 on port 0, read 19 on port 1). Reads 25 and later return 1.
- Undefined: 8-bit registers. buttons2/buttons3 remain as ports but are ignored.

Decomposition:
- Package kctl_pkg:
  - button bit-index constants;
  - SR_WIDTH (8 or 24, selected by the macro);
  - signature constants SIG_P0 = 8'h08, SIG_P1 = 8'h04;
  - default BASE_ADDR.
- Sub-module kctl_shifter, instantiated twice. Inputs: ph0, reset, load, shift, load_value. Output: serial bit. Contains the fill-with-1 shift register.
- Top level holds the address decode, strobe latch and data-bus mux.

Test Plan:
- Reset, then read $4016 with no strobe -> d_out[0] = 1 and d_oe = 1 on every read; open_bus = 8'hE0 gives d_out = 8'hE1.
- buttons0 = 8'hA5; write $4016 = 1 then 0; 10 reads of $4016 -> bits 1,0,1,0,0,1,0,1,1,1.
- Strobe held at 1, buttons0 toggling bit0 each cycle -> every read tracks live bit0; after strobe falls, the first read returns the last sampled bit0.
- buttons0 = 8'hFF, buttons1 = 8'h00; latch; interleave reads $4016/$4017 -> port 0 returns 1s, port 1 returns 0 for 8 reads then 1; no cross-shift. Write to $4017 -> d_oe = 0, strobe unchanged.
- Assert reset after 3 reads of port 0 -> strobe_out = 0, next read returns 1. A read with cyc_valid = 0 at $4016 -> d_oe = 0 and no shift.
- With KCTL_FOUR_SCORE_EN, buttons2 = 8'h01 -> port 0 read 9 = 1, reads 10-16 = 0, read 20 = 1, reads 25 and later = 1; port 1 read 19 = 1.
